neuron_integrate_fire: RTL and testbench
========================================

# neuron_integrate_fire

Per-neuron integrate-and-fire datapath driven by the neuron grid controller's strobes (`new_neuron`, `process_spike`, `update_potential`, `done`). It loads a neuron's stored potential and accumulates signed synaptic weights for every active, connected axon. It then applies leak, threshold and reset, writes the new potential back, and queues output spikes in a small FIFO for the downstream router.

## Interface
Parameters:
- `NUM_NEURONS`, 256, neurons per core; `NID_W = $clog2(NUM_NEURONS)`
- `POT_W`, 9, signed potential/threshold/leak width
- `WEIGHT_W`, 9, signed weight width; must be ≤ `POT_W`
- `NUM_TYPES`, 4, axon types (weights per neuron); `TYPE_W = $clog2(NUM_TYPES)`
- `FIFO_DEPTH`, 4, output spike FIFO depth (power of 2)

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `new_neuron` in 1 — load accumulator for neuron `neuron_id`
- `process_spike` in 1 — integrate one axon this cycle
- `update_potential` in 1 — apply leak/threshold and commit
- `tick_done` in 1 — controller `done`; frame boundary
- `neuron_id` in NID_W — current neuron index
- `current_potential` in POT_W — stored potential of `neuron_id` (signed)
- `axon_spike` in 1 — current axon spiked
- `connected` in 1 — crossbar bit for (axon, neuron)
- `axon_type` in TYPE_W — type of current axon
- `weights` in NUM_TYPES*WEIGHT_W — packed signed weights; type k at bits [k*WEIGHT_W +: WEIGHT_W]
- `leak`, `threshold`, `reset_potential`, `floor_potential` in POT_W each (signed)
- `pot_we` out 1 — write strobe for potential memory
- `pot_waddr` out NID_W — write address
- `pot_wdata` out POT_W — new potential
- `spike_valid` out 1, `spike_ready` in 1, `spike_id` out NID_W — spike stream to router
- `overflow` out 1 — sticky; a spike was dropped because the FIFO was full

## Operation
- Accumulator `acc` is signed POT_W. Next-value logic:
  - base = `new_neuron` ? `current_potential` : `acc`
  - if `process_spike & axon_spike & connected`, `acc` ← sat(base + weights[axon_type]); otherwise `acc` ← base.
  - Weights are sign-extended before the add.
- `neuron_id` is latched into `nid_q` on `new_neuron`.
- sat() clamps to [−2^(POT_W−1), 2^(POT_W−1)−1]. All sums are computed in POT_W+1 bits, then clamped.
- On `update_potential`:
  - v = sat(acc + leak)
  - if v ≥ `threshold`: fire, commit `reset_potential`
  - else if v < `floor_potential`: commit `floor_potential`
  - else: commit v
- The commit drives `pot_we`/`pot_waddr`=`nid_q`/`pot_wdata` as registered outputs. On fire, `nid_q` is pushed to the FIFO.
- FIFO:
  - pop when `spike_valid & spike_ready`
  - push when full: spike is dropped and `overflow` sets. If a pop happens in the same cycle, the push succeeds.
  - `spike_valid` = FIFO not empty; `spike_id` = FIFO head
- `tick_done` clears `overflow`. If a drop happens in the same cycle, set wins.
- Strobes outside this sequence (e.g. `update_potential` with no prior `new_neuron`) are processed literally on the current `acc`; no error checking.

## Timing
- Reset values: `acc`=0, `nid_q`=0, `pot_we`=0, `pot_waddr`=0, `pot_wdata`=0, FIFO empty, `spike_valid`=0, `spike_id`=0, `overflow`=0.
- Integration: weight from a `process_spike` cycle is visible in `acc` the next cycle.
- Commit latency: `update_potential` in cycle N → `pot_we` high for exactly one cycle in N+1. A fire push lands in the FIFO the same cycle, so `spike_valid` rises at N+1 if the FIFO was empty.
- Last axon: `process_spike` may be asserted up to the cycle immediately before `update_potential`, and that axon is included.
- Back-to-back neurons: `new_neuron` may occur in the cycle right after `update_potential`. The commit for the old neuron uses the `nid_q` value captured before the reload.
- `spike_valid`, once high, holds with a stable `spike_id` until popped.
- Reset mid-frame: all state is cleared immediately and the FIFO content is lost.

## Structure
- Shared package `snn_pkg`: default `POT_W`, `WEIGHT_W`, `NUM_TYPES`, and a `sat_add` function (POT_W+1-bit add, clamp).
- One sub-module: `spike_fifo` — synchronous FIFO, parameterised width/depth, with full/empty, simultaneous push/pop and drop-on-full.
- Top level holds the accumulator, threshold compare and commit registers.

## Test plan
- Load `current_potential`=10, 3 connected spiking axons of type 0 (w=5), leak=−1, threshold=100 → `pot_we` at N+1 with `pot_wdata`=24, no spike.
- Potential 90, one axon w=20, threshold=100, `reset_potential`=0, `neuron_id`=7 → `pot_wdata`=0 and `spike_id`=7 valid at N+1.
- Potential 250, weight 100 (POT_W=9) → `acc` saturates at 255. Potential −250, weight −100, `floor_potential`=−200 → commit −200.
- Axon with `axon_spike`=1 but `connected`=0, and axon with `connected`=1 but `axon_spike`=0 → `acc` unchanged.
- `spike_ready`=0, 5 firing neurons → 4 queued, `overflow`=1. `tick_done` → `overflow`=0. Then `spike_ready`=1 → ids drain in firing order.
- Assert `reset` between `new_neuron` and `update_potential` → all outputs return to reset values within the reset cycle; no `pot_we` follows.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared defaults and saturating arithmetic for the spiking-neuron datapath.
package snn_pkg;

  localparam int DEF_POT_W     = 9;
  localparam int DEF_WEIGHT_W  = 9;
  localparam int DEF_NUM_TYPES = 4;

  // Adds two values that already fit in w signed bits, then clamps the sum
  // back into the w-bit signed range. The add has headroom well beyond w+1
  // bits, so the sum itself can never wrap.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Small synchronous FIFO for output spike ids. A push into a full FIFO is
// dropped and flagged, unless a pop in the same cycle frees a slot.
module spike_fifo
  import snn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic              dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              wr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign valid   = ~empty;
  assign pop     = valid & ready;
  assign wr      = push & (~full | pop);
  assign dropped = push & full & ~pop;
  // Storage is not reset, so the head is masked while empty.
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  // Storage write; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers, with a wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/neuron_integrate_fire.sv
// Integrate-and-fire datapath: accumulates weights into a neuron's potential,
// applies leak/threshold/floor on update, writes back and queues spikes.
module neuron_integrate_fire
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int NID_W       = $clog2(NUM_NEURONS),
  parameter int POT_W       = DEF_POT_W,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int NUM_TYPES   = DEF_NUM_TYPES,
  parameter int TYPE_W      = $clog2(NUM_TYPES),
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_neuron,
  input  logic                          process_spike,
  input  logic                          update_potential,
  input  logic                          tick_done,
  input  logic [NID_W-1:0]              neuron_id,
  input  logic [POT_W-1:0]              current_potential,
  input  logic                          axon_spike,
  input  logic                          connected,
  input  logic [TYPE_W-1:0]             axon_type,
  input  logic [NUM_TYPES*WEIGHT_W-1:0] weights,
  input  logic [POT_W-1:0]              leak,
  input  logic [POT_W-1:0]              threshold,
  input  logic [POT_W-1:0]              reset_potential,
  input  logic [POT_W-1:0]              floor_potential,
  output logic                          pot_we,
  output logic [NID_W-1:0]              pot_waddr,
  output logic [POT_W-1:0]              pot_wdata,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [NID_W-1:0]              spike_id,
  output logic                          overflow
);

  function automatic logic signed [POT_W-1:0] sat_pot(input logic signed [POT_W-1:0] a,
                                                      input logic signed [POT_W-1:0] b);
    logic signed [31:0] r;
    r = sat_add(32'(a), 32'(b), POT_W);
    return r[POT_W-1:0];
  endfunction

  logic signed [POT_W-1:0]    acc;
  logic signed [POT_W-1:0]    base;
  logic signed [POT_W-1:0]    acc_next;
  logic signed [WEIGHT_W-1:0] w_sel;
  logic signed [POT_W-1:0]    w_ext;
  logic signed [POT_W-1:0]    v;
  logic signed [POT_W-1:0]    commit_val;
  logic                       fire;
  logic                       hit;
  logic [NID_W-1:0]           nid_q;
  logic                       vld_p1;
  logic [NID_W-1:0]           addr_p1;
  logic signed [POT_W-1:0]    data_p1;
  logic                       dropped;

  // Accumulator next value: reload on new_neuron, then add the selected weight
  // when the current axon both spiked and is wired to this neuron.
  always_comb begin
    base     = new_neuron ? $signed(current_potential) : acc;
    w_sel    = $signed(weights[int'(axon_type)*WEIGHT_W +: WEIGHT_W]);
    w_ext    = POT_W'(w_sel);
    hit      = process_spike & axon_spike & connected;
    acc_next = hit ? sat_pot(base, w_ext) : base;
  end

  // Leak, threshold and floor applied to the current accumulator.
  always_comb begin
    v    = sat_pot(acc, $signed(leak));
    fire = (v >= $signed(threshold));
    if (fire)                            commit_val = $signed(reset_potential);
    else if (v < $signed(floor_potential)) commit_val = $signed(floor_potential);
    else                                 commit_val = v;
  end

  // ---- p0: integration state ----
  // Accumulator and latched neuron id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      nid_q <= '0;
    end else begin
      acc <= acc_next;
      if (new_neuron) nid_q <= neuron_id;
    end
  end

  // ---- p1: commit to potential memory ----
  // One-cycle write strobe; address is the id latched before any same-cycle reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= update_potential;
      if (update_potential) begin
        addr_p1 <= nid_q;
        data_p1 <= commit_val;
      end
    end
  end

  assign pot_we    = vld_p1;
  assign pot_waddr = addr_p1;
  assign pot_wdata = data_p1;

  spike_fifo #(
    .DATA_W (NID_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (update_potential & fire),
    .push_data (nid_q),
    .ready     (spike_ready),
    .valid     (spike_valid),
    .head      (spike_id),
    .dropped   (dropped)
  );

  // Sticky drop flag, cleared at frame boundary; a new drop wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (dropped)   overflow <= 1'b1;
    else if (tick_done) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_neuron_integrate_fire.sv
// Directed bench for neuron_integrate_fire with hand-computed expectations.
module tb_neuron_integrate_fire;

  localparam int NID_W = 8;
  localparam int POT_W = 9;
  localparam int WW    = 9;
  localparam int NT    = 4;
  localparam int TW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            new_neuron, process_spike, update_potential, tick_done;
  logic [NID_W-1:0] neuron_id;
  logic [POT_W-1:0] current_potential;
  logic            axon_spike, connected;
  logic [TW-1:0]    axon_type;
  logic [NT*WW-1:0] weights;
  logic [POT_W-1:0] leak, threshold, reset_potential, floor_potential;
  logic            pot_we;
  logic [NID_W-1:0] pot_waddr;
  logic [POT_W-1:0] pot_wdata;
  logic            spike_valid, spike_ready;
  logic [NID_W-1:0] spike_id;
  logic            overflow;

  int n_asserts = 0;
  int n_fail    = 0;

  neuron_integrate_fire dut (
    .clk               (clk),
    .reset             (reset),
    .new_neuron        (new_neuron),
    .process_spike     (process_spike),
    .update_potential  (update_potential),
    .tick_done         (tick_done),
    .neuron_id         (neuron_id),
    .current_potential (current_potential),
    .axon_spike        (axon_spike),
    .connected         (connected),
    .axon_type         (axon_type),
    .weights           (weights),
    .leak              (leak),
    .threshold         (threshold),
    .reset_potential   (reset_potential),
    .floor_potential   (floor_potential),
    .pot_we            (pot_we),
    .pot_waddr         (pot_waddr),
    .pot_wdata         (pot_wdata),
    .spike_valid       (spike_valid),
    .spike_ready       (spike_ready),
    .spike_id          (spike_id),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [POT_W-1:0] p(input int x);
    return x[POT_W-1:0];
  endfunction

  task automatic check(input string tag, input int actual, input int expected);
    n_asserts++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int id, input int pot);
    neuron_id         = id[NID_W-1:0];
    current_potential = p(pot);
    new_neuron        = 1'b1;
    cyc();
    new_neuron        = 1'b0;
  endtask

  task automatic axon(input logic spk, input logic conn, input int typ);
    axon_spike    = spk;
    connected     = conn;
    axon_type     = typ[TW-1:0];
    process_spike = 1'b1;
    cyc();
    process_spike = 1'b0;
    axon_spike    = 1'b0;
    connected     = 1'b0;
  endtask

  task automatic update();
    update_potential = 1'b1;
    cyc();
    update_potential = 1'b0;
  endtask

  function automatic int spot(input logic [POT_W-1:0] x);
    return int'($signed(x));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    new_neuron = 0; process_spike = 0; update_potential = 0; tick_done = 0;
    neuron_id = '0; current_potential = '0; axon_spike = 0; connected = 0;
    axon_type = '0; spike_ready = 0;
    // type3=-100, type2=100, type1=20, type0=5
    weights = {p(-100), p(100), p(20), p(5)};
    leak = p(0); threshold = p(100); reset_potential = p(0); floor_potential = p(-256);

    cyc(); cyc();
    check("rst_pot_we", int'(pot_we), 0);
    check("rst_pot_waddr", int'(pot_waddr), 0);
    check("rst_pot_wdata", int'(pot_wdata), 0);
    check("rst_spike_valid", int'(spike_valid), 0);
    check("rst_spike_id", int'(spike_id), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_acc", int'(dut.acc), 0);
    reset = 1'b0;
    cyc();

    // Basic integrate with leak, no fire: 10 + 3*5 - 1 = 24
    leak = p(-1);
    start(3, 10);
    axon(1, 1, 0); axon(1, 1, 0); axon(1, 1, 0);
    update();
    check("t1_pot_we", int'(pot_we), 1);
    check("t1_waddr", int'(pot_waddr), 3);
    check("t1_wdata", spot(pot_wdata), 24);
    check("t1_no_spike", int'(spike_valid), 0);
    cyc();
    check("t1_we_one_cycle", int'(pot_we), 0);

    // Fire: 90 + 20 = 110 >= 100 -> commit reset_potential, spike id 7
    leak = p(0);
    start(7, 90);
    axon(1, 1, 1);
    update();
    check("t2_pot_we", int'(pot_we), 1);
    check("t2_waddr", int'(pot_waddr), 7);
    check("t2_wdata", spot(pot_wdata), 0);
    check("t2_spike_valid", int'(spike_valid), 1);
    check("t2_spike_id", int'(spike_id), 7);
    spike_ready = 1'b1;
    cyc();
    spike_ready = 1'b0;
    check("t2_popped", int'(spike_valid), 0);

    // Positive saturation: 250 + 100 -> 255; leak -5 -> 250, below threshold 255
    threshold = p(255); leak = p(-5);
    start(1, 250);
    axon(1, 1, 2);
    check("t3_acc_sat_hi", int'(dut.acc), 255);
    update();
    check("t3_wdata", spot(pot_wdata), 250);
    check("t3_no_spike", int'(spike_valid), 0);

    // Negative saturation and floor: -250 - 100 -> -256 < -200 -> -200
    leak = p(0); threshold = p(100); floor_potential = p(-200);
    start(2, -250);
    axon(1, 1, 3);
    check("t3_acc_sat_lo", int'(dut.acc), -256);
    update();
    check("t3_floor", spot(pot_wdata), -200);
    floor_potential = p(-256);

    // Gating: unconnected spike and connected non-spike leave acc alone
    start(4, 30);
    axon(1, 0, 0);
    check("t4_unconnected", int'(dut.acc), 30);
    axon(0, 1, 1);
    check("t4_no_spike", int'(dut.acc), 30);
    update();
    check("t4_wdata", spot(pot_wdata), 30);

    // Overflow: five fires into a four-deep FIFO with no ready
    for (int i = 0; i < 5; i++) begin
      start(10 + i, 90);
      axon(1, 1, 1);
      update();
      check("t5_waddr", int'(pot_waddr), 10 + i);
      if (i < 4) check("t5_no_overflow", int'(overflow), 0);
    end
    check("t5_overflow", int'(overflow), 1);
    check("t5_head", int'(spike_id), 10);
    tick_done = 1'b1;
    cyc();
    tick_done = 1'b0;
    check("t5_tick_clear", int'(overflow), 0);
    spike_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_valid", int'(spike_valid), 1);
      check("t5_drain_id", int'(spike_id), 10 + i);
      cyc();
    end
    spike_ready = 1'b0;
    check("t5_drained", int'(spike_valid), 0);

    // Reset between new_neuron and update: everything clears, no commit after
    start(9, 90); axon(1, 1, 1); update();
    check("t6_pre_valid", int'(spike_valid), 1);
    start(5, 90);
    axon(1, 1, 1);
    reset = 1'b1;
    #1;
    check("t6_acc", int'(dut.acc), 0);
    check("t6_valid", int'(spike_valid), 0);
    check("t6_id", int'(spike_id), 0);
    check("t6_we", int'(pot_we), 0);
    check("t6_wdata", int'(pot_wdata), 0);
    check("t6_waddr", int'(pot_waddr), 0);
    check("t6_overflow", int'(overflow), 0);
    update_potential = 1'b1;
    cyc();
    update_potential = 1'b0;
    reset = 1'b0;
    cyc();
    check("t6_no_we_1", int'(pot_we), 0);
    cyc();
    check("t6_no_we_2", int'(pot_we), 0);
    check("t6_still_empty", int'(spike_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
